// File: rtl/button_pkg.sv
// Shared widths, divider math and reset constants for the push-button front end.
// Imported by the tick divider and the event arbiter top.
package button_pkg;

  // Bit width needed to index n items; never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int div_of(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // The round-robin pointer resets to the last index so button 0 is searched first.
  function automatic int rr_reset_of(input int num_buttons);
    return num_buttons - 1;
  endfunction

  localparam int DIV_RESET = 0;

endpackage

// File: rtl/tick_divider.sv
// Shared sampling-tick generator: a free-running 0..DIV-1 counter whose last
// count produces a single-cycle tick.
module tick_divider
  import button_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV   = div_of(CLK_HZ, SAMPLE_HZ);
  localparam int CNT_W = width_of(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_W'(DIV_RESET);
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/button_event_arbiter.sv
// Push-button front end: synchronise, debounce on a shared tick, detect presses,
// round-robin them into an event FIFO drained by a valid/ready consumer.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_BUTTONS-1:0]           btn_in,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [width_of(NUM_BUTTONS)-1:0] evt_idx,
  output logic                             evt_overflow,
  input  logic                             clear_overflow,
  output logic [NUM_BUTTONS-1:0]           pending
);

  localparam int IDX_W = width_of(NUM_BUTTONS);
  localparam int PTR_W = width_of(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] RR_RESET  = IDX_W'(rr_reset_of(NUM_BUTTONS));
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  logic                   tick, tick_d;
  logic [NUM_BUTTONS-1:0] sync_q, btn_s, state, prev, rise, grant_vec;
  logic [IDX_W-1:0]       rr_last, grant_idx, cand;
  logic                   grant_any, merge, push, pop;

  logic [IDX_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_count;

  tick_divider #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchroniser every clk; debounced state only moves on the shared tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      btn_s  <= '0;
      state  <= '0;
      prev   <= '0;
      tick_d <= 1'b0;
    end else begin
      sync_q <= btn_in;
      btn_s  <= sync_q;
      tick_d <= tick;
      if (tick) begin
        prev  <= state;
        state <= btn_s;
      end
    end
  end

  assign rise = {NUM_BUTTONS{tick_d}} & state & ~prev;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_vec = '0;
    if (fifo_count < FIFO_FULL) begin
      // Walk the search order backwards so the nearest candidate after rr_last wins.
      for (int k = NUM_BUTTONS; k >= 1; k--) begin
        cand = IDX_W'((int'(rr_last) + k) % NUM_BUTTONS);
        if (pending[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  assign merge = |(rise & pending & ~grant_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      rr_last      <= RR_RESET;
      evt_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant_vec) | rise;
      if (grant_any) rr_last <= grant_idx;
      if (merge) begin
        evt_overflow <= 1'b1;
      end else if (clear_overflow) begin
        evt_overflow <= 1'b0;
      end
    end
  end

  assign push = grant_any;
  assign pop  = evt_valid & evt_ready;

  // NOTE: the FIFO storage is reset too; it is tiny, and it keeps evt_idx at 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= grant_idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign evt_valid = (fifo_count != '0);
  assign evt_idx   = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a 10-clk sampling tick; cyc counts
// posedges since reset release, so debounced state moves at cyc 10, 20, 30, ...
module tb_button_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_idx;
  logic         evt_overflow;
  logic         clear_overflow;
  logic [N-1:0] pending;

  int checks   = 0;
  int failures = 0;
  int cyc;

  button_event_arbiter #(
    .NUM_BUTTONS(N),
    .CLK_HZ     (100),
    .SAMPLE_HZ  (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_idx       (evt_idx),
    .evt_overflow  (evt_overflow),
    .clear_overflow(clear_overflow),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  // Advance on falling edges until the bench cycle counter reaches t.
  task automatic to_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) begin
      failures++;
      $display("FAIL cyc_align: at cyc %0d wanted %0d", cyc, t);
    end
  endtask

  task automatic reset_assert();
    rst_n          = 1'b0;
    btn_in         = '0;
    evt_ready      = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic reset_release();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic full_reset();
    @(negedge clk);
    reset_assert();
    reset_release();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values and tick spacing
    reset_assert();
    #1;
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_idx", 32'(evt_idx), 0);
    check("rst_ovf", 32'(evt_overflow), 0);
    check("rst_pending", 32'(pending), 0);
    reset_release();
    to_cyc(8);  check("tick_c8", 32'(dut.u_tick.tick), 0);
    to_cyc(9);  check("tick_c9", 32'(dut.u_tick.tick), 1);
    to_cyc(10); check("tick_c10", 32'(dut.u_tick.tick), 0);
    to_cyc(19); check("tick_c19", 32'(dut.u_tick.tick), 1);
    to_cyc(29); check("tick_c29", 32'(dut.u_tick.tick), 1);

    // 4: round-robin bursts
    full_reset();
    evt_ready = 1'b1;
    to_cyc(5);  btn_in = 4'b1011;
    to_cyc(11); check("rr1_pending", 32'(pending), 32'b1011);
                check("rr1_valid_early", 32'(evt_valid), 0);
    to_cyc(12); check("rr1_idx_a", 32'(evt_idx), 0);
                check("rr1_valid_a", 32'(evt_valid), 1);
                check("rr1_pending_a", 32'(pending), 32'b1010);
    to_cyc(13); check("rr1_idx_b", 32'(evt_idx), 1);
    to_cyc(14); check("rr1_idx_c", 32'(evt_idx), 3);
    to_cyc(15); check("rr1_drained", 32'(evt_valid), 0);
                btn_in = 4'b0000;
    to_cyc(25); btn_in = 4'b1001;
    to_cyc(32); check("rr2_idx_a", 32'(evt_idx), 0);
    to_cyc(33); check("rr2_idx_b", 32'(evt_idx), 3);
    to_cyc(34); check("rr2_drained", 32'(evt_valid), 0);
                btn_in = 4'b0000;
    to_cyc(45); btn_in = 4'b0010;
    to_cyc(52); check("rr3_idx", 32'(evt_idx), 1);
    to_cyc(55); btn_in = 4'b0000;
    to_cyc(65); btn_in = 4'b1001;
    to_cyc(72); check("rr4_idx_a", 32'(evt_idx), 3);
    to_cyc(73); check("rr4_idx_b", 32'(evt_idx), 0);
    to_cyc(74); check("rr4_drained", 32'(evt_valid), 0);

    // 2: single long press
    full_reset();
    to_cyc(5);  btn_in = 4'b0100;
    to_cyc(11); check("sp_pending", 32'(pending), 32'b0100);
                check("sp_valid_early", 32'(evt_valid), 0);
    to_cyc(12); check("sp_valid", 32'(evt_valid), 1);
                check("sp_idx", 32'(evt_idx), 2);
    to_cyc(55); check("sp_hold_valid", 32'(evt_valid), 1);
                check("sp_hold_pending", 32'(pending), 0);
                evt_ready = 1'b1;
    to_cyc(56); evt_ready = 1'b0;
                check("sp_single_event", 32'(evt_valid), 0);
    to_cyc(65); check("sp_no_repeat_valid", 32'(evt_valid), 0);
                check("sp_no_repeat_pending", 32'(pending), 0);
                check("sp_ovf", 32'(evt_overflow), 0);

    // 3: bounce between two ticks, then steady press
    full_reset();
    to_cyc(10);
    for (int i = 0; i < 8; i++) begin
      btn_in[1] = ~i[0];
      @(negedge clk);
    end
    btn_in[1] = 1'b1;
    to_cyc(21); check("bn_no_event", 32'(pending), 0);
    to_cyc(22); check("bn_no_valid", 32'(evt_valid), 0);
    to_cyc(31); check("bn_pending", 32'(pending), 32'b0010);
    to_cyc(32); check("bn_idx", 32'(evt_idx), 1);
                check("bn_valid", 32'(evt_valid), 1);
                evt_ready = 1'b1;
    to_cyc(33); evt_ready = 1'b0;
                check("bn_popped", 32'(evt_valid), 0);
    to_cyc(45); check("bn_once_valid", 32'(evt_valid), 0);
                check("bn_once_pending", 32'(pending), 0);

    // 5: full FIFO, merge, overflow, clear
    full_reset();
    to_cyc(5);  btn_in = 4'b0001;
    to_cyc(15); btn_in = 4'b0010;
    to_cyc(25); btn_in = 4'b0100;
    to_cyc(35); btn_in = 4'b1000;
    to_cyc(43); check("ff_head", 32'(evt_idx), 0);
                check("ff_valid", 32'(evt_valid), 1);
    to_cyc(45); btn_in = 4'b0001;
    to_cyc(51); check("ff_blocked_pending", 32'(pending), 32'b0001);
                check("ff_ovf_clear", 32'(evt_overflow), 0);
    to_cyc(55); btn_in = 4'b0000;
    to_cyc(65); btn_in = 4'b0001;
    to_cyc(71); check("ff_merge_pending", 32'(pending), 32'b0001);
                check("ff_merge_ovf", 32'(evt_overflow), 1);
                check("ff_head_kept", 32'(evt_idx), 0);
    to_cyc(72); evt_ready = 1'b1;
    to_cyc(73); evt_ready = 1'b0;
                check("ff_pop_head", 32'(evt_idx), 1);
                check("ff_pop_pending", 32'(pending), 32'b0001);
    to_cyc(74); check("ff_refill_pending", 32'(pending), 0);
                check("ff_order_1", 32'(evt_idx), 1);
                evt_ready = 1'b1;
    to_cyc(75); check("ff_order_2", 32'(evt_idx), 2);
                btn_in = 4'b0000;
    to_cyc(76); check("ff_order_3", 32'(evt_idx), 3);
    to_cyc(77); check("ff_order_0", 32'(evt_idx), 0);
    to_cyc(78); check("ff_empty", 32'(evt_valid), 0);
                check("ff_ovf_sticky", 32'(evt_overflow), 1);
                evt_ready      = 1'b0;
                clear_overflow = 1'b1;
    to_cyc(79); clear_overflow = 1'b0;
                check("ff_ovf_cleared", 32'(evt_overflow), 0);

    // 6: asynchronous reset with events queued
    full_reset();
    to_cyc(5);  btn_in = 4'b1000;
    to_cyc(15); btn_in = 4'b0010;
    to_cyc(25); btn_in = 4'b0100;
    to_cyc(33); check("ar_queued_head", 32'(evt_idx), 3);
                check("ar_queued_valid", 32'(evt_valid), 1);
    to_cyc(35);
    #2;
    reset_assert();
    #1;
    check("ar_valid_now", 32'(evt_valid), 0);
    check("ar_pending_now", 32'(pending), 0);
    check("ar_idx_now", 32'(evt_idx), 0);
    reset_release();
    evt_ready = 1'b1;
    to_cyc(5);  btn_in = 4'b1001;
    to_cyc(9);  check("ar_no_replay_valid", 32'(evt_valid), 0);
                check("ar_no_replay_pending", 32'(pending), 0);
    to_cyc(11); check("ar_pending", 32'(pending), 32'b1001);
    to_cyc(12); check("ar_rr_first", 32'(evt_idx), 0);
    to_cyc(13); check("ar_rr_second", 32'(evt_idx), 3);
    to_cyc(14); check("ar_drained", 32'(evt_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
